// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command sequencer: FSM state encoding,
// ALU function-group codes and per-group result byte counts.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    SEND  = 2'b11
  } state_t;

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_CMP   = 2'b10;
  localparam logic [1:0] GRP_SHIFT = 2'b11;

  localparam int ARITH_BYTES  = 4;
  localparam int NARROW_BYTES = 2;

  // Arithmetic results use the full double-width result; all other groups
  // only produce meaningful data in the low operand-width bits.
  function automatic logic is_wide_group(input logic [1:0] grp);
    return (grp == GRP_ARITH);
  endfunction

endpackage

// File: rtl/alu_res_serializer.sv
// Result serializer: captures an ALU result plus a byte count, then presents
// the bytes LSB-first on a valid/ready stream. last_done pulses (combinational)
// on the handshake of the final byte so the controller can return to idle.
module alu_res_serializer #(
  parameter int RES_WIDTH  = 32,
  parameter int BYTE_WIDTH = 8,
  localparam int NBYTES    = RES_WIDTH / BYTE_WIDTH,
  localparam int IDX_W     = $clog2(NBYTES),
  localparam int CNT_W     = $clog2(NBYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [RES_WIDTH-1:0]  load_res,
  input  logic [CNT_W-1:0]      load_cnt,
  output logic [BYTE_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  last_done
);

  logic [RES_WIDTH-1:0]  res_q, res_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BYTE_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [BYTE_WIDTH-1:0] res_bytes [NBYTES];
  logic                  hs;
  logic                  is_last;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign res_bytes[gi] = res_q[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endgenerate

  assign hs        = valid_q & tx_ready;
  assign is_last   = ((CNT_W'(idx_q) + CNT_W'(1)) == cnt_q);
  assign last_done = hs & is_last;
  assign tx_data   = data_q;
  assign tx_valid  = valid_q;

  // Next-state: load presents byte 0 immediately; each handshake advances
  // the index, and the byte register only changes on a handshake so the
  // output is stable under backpressure.
  always_comb begin
    res_d   = res_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      res_d   = load_res;
      idx_d   = '0;
      cnt_d   = load_cnt;
      data_d  = load_res[BYTE_WIDTH-1:0];
      valid_d = 1'b1;
    end else if (hs) begin
      if (is_last) begin
        valid_d = 1'b0;
      end else begin
        idx_d  = idx_q + 1'b1;
        data_d = res_bytes[idx_d];
      end
    end
  end

  // Serializer state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// ALU command sequencer: accepts one command, drives the ALU until its result
// is valid, then streams the result bytes LSB-first to the TX path.
// Optional build macro ALU_TIMEOUT_EN adds a WAIT-state watchdog that pulses
// ERR and abandons the command if the ALU never answers.
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int FUN_WIDTH      = 4,
  parameter int BYTE_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_Valid,
  output logic                    CMD_Ready,
  input  logic [FUN_WIDTH-1:0]    CMD_FUN,
  input  logic [DATA_WIDTH-1:0]   CMD_A,
  input  logic [DATA_WIDTH-1:0]   CMD_B,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    ALU_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_Valid,
  output logic [BYTE_WIDTH-1:0]   TX_DATA,
  output logic                    TX_Valid,
  input  logic                    TX_Ready,
  output logic                    Busy,
  output logic                    ERR
);

  localparam int RES_BYTES = (2 * DATA_WIDTH) / BYTE_WIDTH;
  localparam int BCNT_W    = $clog2(RES_BYTES + 1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
  logic                    alu_en_q, alu_en_d;
  logic                    err_q, err_d;
  logic                    cmd_hs;
  logic                    ser_load;
  logic [BCNT_W-1:0]       ser_cnt;
  logic                    ser_done;

`ifdef ALU_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
`endif

  assign CMD_Ready = RST & (state_q == IDLE);
  assign Busy      = RST & (state_q != IDLE);
  assign cmd_hs    = CMD_Valid & CMD_Ready;
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;
  assign ALU_EN    = alu_en_q;
  assign ERR       = err_q;
  assign ser_cnt   = is_wide_group(alu_fun_q[3:2]) ? BCNT_W'(ARITH_BYTES)
                                                   : BCNT_W'(NARROW_BYTES);

  alu_res_serializer #(
    .RES_WIDTH  (2 * DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_ser (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (ser_load),
    .load_res  (ALU_OUT),
    .load_cnt  (ser_cnt),
    .tx_data   (TX_DATA),
    .tx_valid  (TX_Valid),
    .tx_ready  (TX_Ready),
    .last_done (ser_done)
  );

  // Sequencer next-state: latch command, enable ALU, wait for its result
  // (or watchdog expiry), hand the result to the serializer.
  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fun_d = alu_fun_q;
    alu_en_d  = alu_en_q;
    err_d     = 1'b0;
    ser_load  = 1'b0;
`ifdef ALU_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          alu_a_d   = CMD_A;
          alu_b_d   = CMD_B;
          alu_fun_d = CMD_FUN;
          alu_en_d  = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        alu_en_d = 1'b1;
        state_d  = WAIT;
`ifdef ALU_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      WAIT: begin
        // A valid result takes priority over a watchdog expiry in the same cycle.
        if (ALU_OUT_Valid) begin
          ser_load = 1'b1;
          alu_en_d = 1'b0;
          state_d  = SEND;
        end
`ifdef ALU_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d    = 1'b1;
          alu_en_d = 1'b0;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      SEND: begin
        if (ser_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; reset abandons any command in progress.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
      alu_en_q  <= 1'b0;
      err_q     <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_fun_q <= alu_fun_d;
      alu_en_q  <= alu_en_d;
      err_q     <= err_d;
`ifdef ALU_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Sequencer between the system controller and the ALU.
- Accepts one ALU command (function code plus two operands) per valid/ready handshake.
- Drives the ALU operand, function and enable inputs, then waits for the ALU output-valid flag and captures the result.
- Serializes the result LSB-first as bytes to the TX path (UART TX FIFO) over a valid/ready interface.
- One command is in flight at a time.

Parameters:
- DATA_WIDTH, 16, ALU operand width; the ALU result is 2*DATA_WIDTH.
- FUN_WIDTH, 4, ALU function-code width.
- BYTE_WIDTH, 8, TX byte width.
- TIMEOUT_CYCLES, 8, WAIT-state watchdog limit in cycles. Used only when ALU_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-low reset
- CMD_Valid  in  1  command present
- CMD_Ready  out  1  command accepted when CMD_Valid and CMD_Ready are both 1
- CMD_FUN  in  FUN_WIDTH  ALU function code
- CMD_A  in  DATA_WIDTH  operand A
- CMD_B  in  DATA_WIDTH  operand B
- ALU_A  out  DATA_WIDTH  operand A to the ALU
- ALU_B  out  DATA_WIDTH  operand B to the ALU
- ALU_FUN  out  FUN_WIDTH  function code to the ALU
- ALU_EN  out  1  ALU enable
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- ALU_OUT_Valid  in  1  ALU result valid
- TX_DATA  out  BYTE_WIDTH  result byte
- TX_Valid  out  1  byte present
- TX_Ready  in  1  byte accepted when TX_Valid and TX_Ready are both 1
- Busy  out  1  high in every state except IDLE
- ERR  out  1  one-cycle timeout pulse

Behaviour:
- Reset: when RST=0 at a CLK edge, state goes to IDLE and all registered outputs clear: ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_Valid, ERR, byte index and result register all 0. CMD_Ready and Busy are forced to 0 while RST=0. Reset in any state aborts the command; the partial byte stream is abandoned.
- FSM states: IDLE, ISSUE, WAIT, SEND.
- IDLE:
  - CMD_Ready=1.
  - On handshake, register CMD_FUN, CMD_A and CMD_B onto ALU_FUN, ALU_A and ALU_B, then go to ISSUE.
- ISSUE:
  - ALU_EN=1. Go to WAIT.
- WAIT:
  - ALU_EN stays 1; ALU_A, ALU_B and ALU_FUN are held stable.
  - On ALU_OUT_Valid=1, capture ALU_OUT into the result register, set ALU_EN=0, clear the byte index and go to SEND.
  - ALU_OUT_Valid is ignored in every other state.
- Byte count by function group ALU_FUN[3:2]:
  - 2'b00 (arithmetic): 4 bytes.
  - All other groups (logic, compare, shift): 2 bytes, i.e. the low DATA_WIDTH bits.
- SEND:
  - TX_Valid=1 and TX_DATA = result[8*idx +: 8].
  - TX_DATA must stay stable while TX_Ready=0.
  - On handshake, idx increments.
  - On the handshake of the last byte, TX_Valid=0 next cycle and state goes to IDLE.
- Latency with a 1-cycle registered ALU and TX_Ready held at 1:
  - Handshake in cycle 0; ALU_EN=1 in cycles 1–2; ALU_OUT_Valid in cycle 2; first TX_Valid in cycle 3.
  - Last byte in cycle 6 (arithmetic) or cycle 4 (other groups). CMD_Ready is 1 in the following cycle.
- A CMD_Valid asserted while Busy is held off (CMD_Ready=0). No queuing.
- A function code the ALU does not decode produces no ALU_OUT_Valid. This is covered only by the timeout feature.

Optional Feature:
ALU_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ALU_OUT_Valid.
  - When the counter reaches TIMEOUT_CYCLES: ERR pulses for 1 cycle, ALU_EN=0, no bytes are sent, state goes to IDLE.
  - If ALU_OUT_Valid arrives in the same cycle the limit is reached, the valid result wins.
- Undefined: no counter; WAIT lasts indefinitely; ERR is tied to 0.

Decomposition:
- Package alu_ctrl_pkg holds:
  - state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, SEND=2'b11);
  - function-group constants (GRP_ARITH=2'b00, GRP_LOGIC=2'b01, GRP_CMP=2'b10, GRP_SHIFT=2'b11);
  - byte counts (ARITH_BYTES=4, NARROW_BYTES=2).
- One sub-module, alu_res_serializer: loads the result and byte count, then steps through the bytes with TX valid/ready and signals last-byte-done to the FSM.

Test Plan:
- ADD: FUN=4'b0000, A=0x0003, B=0x0004; ALU returns 0x00000007. TX must emit 07,00,00,00, then CMD_Ready=1.
- MUL: FUN=4'b0010, A=0x1234, B=0x0100; ALU returns 0x00123400. TX must emit 00,34,12,00.
- AND: FUN=4'b0100, A=0xF0F0, B=0xFF00; ALU returns 0x0000F000. TX must emit exactly 00,F0; Busy falls after the second byte.
- Backpressure: TX_Ready=0 for 5 cycles on byte 1. TX_DATA and TX_Valid must stay stable and no bytes may be lost or duplicated. A second CMD_Valid during SEND must see CMD_Ready=0.
- Timeout (ALU_TIMEOUT_EN defined): ALU_OUT_Valid held at 0. ERR must pulse once 8 cycles after WAIT entry, with no TX_Valid, and CMD_Ready=1 on the next cycle.
- Reset mid-SEND: RST=0 after the first byte. Next cycle all outputs must be 0; after release, a new ADD 1+1 must yield 02,00,00,00.
